// File: rtl/store_commit_buffer.sv
// Store commit buffer: in-order FIFO of resolved stores held until the ROB commits them,
// then drained to data memory one write at a time over a req/ack handshake.
module store_commit_buffer #(
    parameter int DEPTH = 4,
    parameter int ROB_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             storeEnable,
    input  logic [ROB_W-1:0] robNum_in,
    input  logic [31:0]      data_in,
    input  logic [31:0]      addr_in,
    input  logic [2:0]       subType_in,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    input  logic             commit_valid,
    input  logic [ROB_W-1:0] commit_rob,
    input  logic             flush,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byteEn,
    input  logic             mem_ack,
    output logic             misalign,
    input  logic [31:0]      load_addr,
    output logic             load_conflict
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    function automatic logic [3:0] lane_be(input logic [2:0] st, input logic [1:0] lo);
        case (st)
            3'b000:  lane_be = 4'b0001 << lo;
            3'b001:  lane_be = lo[1] ? 4'b1100 : 4'b0011;
            3'b010:  lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] st, input logic [31:0] d);
        case (st)
            3'b000:  lane_data = {4{d[7:0]}};
            3'b001:  lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] st, input logic [1:0] lo);
        case (st)
            3'b001:  is_misaligned = lo[0];
            3'b010:  is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    logic [DEPTH-1:0] valid_q, valid_d, cmt_q, cmt_d;
    logic [ROB_W-1:0] tag_q [DEPTH];
    logic [ROB_W-1:0] tag_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [2:0]       sub_q [DEPTH];
    logic [2:0]       sub_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, idx_s;
    logic [CW-1:0]    count_q, count_d, keep_len_s;
    logic             full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
    logic [0:0]       state_q, state_d;
    logic             mem_req_q, mem_req_d, misalign_q, misalign_d;
    logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic             launch_s, skip_s, pop_s, enq_s, conflict_s;

    // Drain handshake decode; an invalid head left behind by a flush is skipped
    always_comb begin
        launch_s = (state_q == ST_IDLE) && valid_q[head_q] && cmt_q[head_q];
        skip_s   = (state_q == ST_IDLE) && !valid_q[head_q] && (count_q != CW'(0));
        pop_s    = ((state_q == ST_REQ) && mem_ack) || skip_s;
        enq_s    = storeEnable && !full_q && !flush;
    end

    // Entry array, pointers and occupancy: commit first, then pop, then flush or enqueue
    always_comb begin
        valid_d    = valid_q;
        tag_d      = tag_q;
        data_d     = data_q;
        addr_d     = addr_q;
        sub_d      = sub_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        keep_len_s = CW'(0);
        idx_s      = head_q;
        overflow_d = overflow_q | (storeEnable & full_q);
        for (int i = 0; i < DEPTH; i++) begin
            cmt_d[i] = cmt_q[i] | (commit_valid & valid_q[i] & (tag_q[i] == commit_rob));
        end
        if (pop_s) begin
            valid_d[head_q] = 1'b0;
            cmt_d[head_q]   = 1'b0;
            head_d          = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end
        if (flush) begin
            // Tail rewinds to just past the youngest surviving committed entry
            for (int k = 0; k < DEPTH; k++) begin
                idx_s = head_q + PW'(k);
                if ((CW'(k) < count_q) && cmt_d[idx_s]) begin
                    keep_len_s = CW'(k + 1);
                end else begin
                    keep_len_s = keep_len_s;
                end
            end
            valid_d = valid_d & cmt_d;
            if (keep_len_s == CW'(0)) begin
                tail_d  = head_d;
                count_d = CW'(0);
            end else begin
                tail_d  = head_q + keep_len_s[PW-1:0];
                count_d = keep_len_s - CW'(pop_s);
            end
        end else begin
            if (enq_s) begin
                valid_d[tail_q] = 1'b1;
                cmt_d[tail_q]   = commit_valid && (commit_rob == robNum_in);
                tag_d[tail_q]   = robNum_in;
                data_d[tail_q]  = data_in;
                addr_d[tail_q]  = addr_in;
                sub_d[tail_q]   = subType_in;
                tail_d          = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + CW'(enq_s) - CW'(pop_s);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
    end

    // Two-state drain FSM driving the memory write port
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        misalign_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (launch_s) begin
                    state_d     = ST_REQ;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {addr_q[head_q][31:2], 2'b00};
                    mem_wdata_d = lane_data(sub_q[head_q], data_q[head_q]);
                    mem_be_d    = lane_be(sub_q[head_q], addr_q[head_q][1:0]);
                    misalign_d  = is_misaligned(sub_q[head_q], addr_q[head_q][1:0]);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Load alias probe against every valid entry at word granularity
    always_comb begin
        conflict_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            conflict_s = conflict_s | (valid_q[i] & (addr_q[i][31:2] == load_addr[31:2]));
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q     <= {DEPTH{1'b0}};
            cmt_q       <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= {ROB_W{1'b0}};
                data_q[i] <= 32'h0000_0000;
                addr_q[i] <= 32'h0000_0000;
                sub_q[i]  <= 3'b000;
            end
            head_q      <= {PW{1'b0}};
            tail_q      <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            misalign_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            cmt_q       <= cmt_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            sub_q       <= sub_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            misalign_q  <= misalign_d;
        end
    end

    assign full          = full_q;
    assign empty         = empty_q;
    assign overflow      = overflow_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_byteEn    = mem_be_q;
    assign misalign      = misalign_q;
    assign load_conflict = conflict_s;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: queue-based reference model predicts each memory write;
// a monitor compares every rising mem_req against the predicted request queue.
module tb_store_commit_buffer;
    localparam int DEPTH = 4;

    logic        clock, reset, storeEnable, commit_valid, flush, mem_ack;
    logic [5:0]  robNum_in, commit_rob;
    logic [31:0] data_in, addr_in, load_addr;
    logic [2:0]  subType_in;
    logic        full, empty, overflow, mem_req, misalign, load_conflict;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_byteEn;

    typedef struct { logic [5:0] tag; logic [31:0] data; logic [31:0] addr; logic [2:0] st; bit cmt; } ent_t;
    typedef struct { logic [31:0] addr; logic [31:0] wd; logic [3:0] be; logic mis; } req_t;

    ent_t       mq[$];
    req_t       eq[$];
    req_t       r_mon;
    bit         busy, ovf, prev_req;
    int         n_cmp, n_bad;
    logic [5:0] nt;

    store_commit_buffer #(.DEPTH(DEPTH), .ROB_W(6)) dut (
        .clock(clock), .reset(reset), .storeEnable(storeEnable), .robNum_in(robNum_in),
        .data_in(data_in), .addr_in(addr_in), .subType_in(subType_in), .full(full),
        .empty(empty), .overflow(overflow), .commit_valid(commit_valid), .commit_rob(commit_rob),
        .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteEn(mem_byteEn), .mem_ack(mem_ack), .misalign(misalign),
        .load_addr(load_addr), .load_conflict(load_conflict)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Write formatting straight from the lane rules
    function automatic req_t fmt(input ent_t e);
        req_t r;
        r.addr = e.addr & 32'hFFFF_FFFC;
        case (e.st)
            3'd0: begin r.be = 4'(1 << (e.addr % 4)); r.wd = {24'h0, e.data[7:0]} * 32'h0101_0101; r.mis = 1'b0; end
            3'd1: begin r.be = ((e.addr % 4) >= 2) ? 4'hC : 4'h3; r.wd = {16'h0, e.data[15:0]} * 32'h0001_0001;
                        r.mis = (e.addr % 2) == 1; end
            3'd2: begin r.be = 4'hF; r.wd = e.data; r.mis = (e.addr % 4) != 0; end
            default: begin r.be = 4'h0; r.wd = e.data; r.mis = 1'b0; end
        endcase
        return r;
    endfunction

    // Monitor: every fresh request must match the oldest predicted one
    always @(posedge clock) begin
        #1;
        if (reset) begin
            if (mem_req && !prev_req) begin
                if (eq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_req: got mem_req=1 mem_addr=0x%08h, expected no request", mem_addr);
                end else begin
                    r_mon = eq.pop_front();
                    chk("req_addr", mem_addr, r_mon.addr);
                    chk("req_byteEn", {28'h0, mem_byteEn}, {28'h0, r_mon.be});
                    if (r_mon.be != 4'h0) chk("req_wdata", mem_wdata, r_mon.wd);
                    chk("req_misalign", {31'h0, misalign}, {31'h0, r_mon.mis});
                end
            end else begin
                chk("misalign_quiet", {31'h0, misalign}, 32'h0);
            end
        end
        prev_req = mem_req;
    end

    task automatic zero_inputs();
        storeEnable = 1'b0; robNum_in = 6'd0; data_in = 32'h0; addr_in = 32'h0; subType_in = 3'd0;
        commit_valid = 1'b0; commit_rob = 6'd0; flush = 1'b0; mem_ack = 1'b0; load_addr = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        zero_inputs();
        mq.delete(); eq.delete(); busy = 1'b0; ovf = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_overflow", {31'h0, overflow}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_byteEn", {28'h0, mem_byteEn}, 32'h0);
        chk("rst_misalign", {31'h0, misalign}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One clock: drive inputs, advance the reference model, check status outputs
    task automatic cyc(input logic se, input logic [5:0] tg, input logic [31:0] d, input logic [31:0] a,
                       input logic [2:0] st, input logic cv, input logic [5:0] cr, input logic fl,
                       input logic ak, input logic [31:0] la);
        ent_t e;
        int   sz;
        bit   launch, pop, lc;
        @(negedge clock);
        storeEnable = se; robNum_in = tg; data_in = d; addr_in = a; subType_in = st;
        commit_valid = cv; commit_rob = cr; flush = fl; mem_ack = ak; load_addr = la;
        sz     = mq.size();
        launch = !busy && (sz > 0) && mq[0].cmt;
        pop    = busy && ak;
        if (se && sz == DEPTH) ovf = 1'b1;
        if (cv) foreach (mq[i]) if (mq[i].tag == cr) mq[i].cmt = 1'b1;
        if (launch) begin eq.push_back(fmt(mq[0])); busy = 1'b1; end
        if (pop) begin void'(mq.pop_front()); busy = 1'b0; end
        if (fl) begin
            for (int i = mq.size() - 1; i >= 0; i--) if (!mq[i].cmt) mq.delete(i);
        end else if (se && sz < DEPTH) begin
            e.tag = tg; e.data = d; e.addr = a; e.st = st; e.cmt = cv && (cr == tg);
            mq.push_back(e);
            nt = nt + 6'd1;
        end
        lc = 1'b0;
        foreach (mq[i]) if (mq[i].addr[31:2] == la[31:2]) lc = 1'b1;
        @(posedge clock);
        #1;
        chk("full", {31'h0, full}, {31'h0, mq.size() == DEPTH});
        chk("empty", {31'h0, empty}, {31'h0, mq.size() == 0});
        chk("overflow", {31'h0, overflow}, {31'h0, ovf});
        chk("load_conflict", {31'h0, load_conflict}, {31'h0, lc});
    endtask

    task automatic idle(input logic ak);
        cyc(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b0, 6'd0, 1'b0, ak, 32'h0);
    endtask

    task automatic enq(input logic [5:0] tg, input logic [31:0] d, input logic [31:0] a,
                       input logic [2:0] st, input logic cv);
        cyc(1'b1, tg, d, a, st, cv, tg, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time expired, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       se, cv, fl, ak;
        logic [5:0] cr;
        logic [2:0] st;
        logic [31:0] a, la;
        int         idx, pick;
        n_cmp = 0; n_bad = 0; nt = 6'd0; prev_req = 1'b0;
        do_reset();

        // Basic SW: commit, one-cycle launch latency, ack empties the buffer
        enq(6'd5, 32'hDEAD_BEEF, 32'h104, 3'd2, 1'b0);
        cyc(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b1, 6'd5, 1'b0, 1'b0, 32'h0);
        chk("sw_req_not_yet", {31'h0, mem_req}, 32'h0);
        idle(1'b0);
        chk("sw_req", {31'h0, mem_req}, 32'h1);
        chk("sw_addr", mem_addr, 32'h104);
        chk("sw_be", {28'h0, mem_byteEn}, 32'hF);
        chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        idle(1'b1);
        chk("sw_empty_after_ack", {31'h0, empty}, 32'h1);
        chk("sw_req_dropped", {31'h0, mem_req}, 32'h0);

        // SB and SH lane formatting
        enq(6'd6, 32'h0000_00AB, 32'h203, 3'd0, 1'b1);
        idle(1'b0);
        chk("sb_be", {28'h0, mem_byteEn}, 32'h8);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        idle(1'b1);
        enq(6'd7, 32'h0000_1234, 32'h202, 3'd1, 1'b1);
        idle(1'b0);
        chk("sh_be", {28'h0, mem_byteEn}, 32'hC);
        chk("sh_wdata", mem_wdata, 32'h1234_1234);
        idle(1'b1);

        // Fill, overflow, drain in order
        for (int t = 1; t <= 4; t++) enq(6'(t), 32'(t), 32'h400 + 32'(4 * t), 3'd2, 1'b0);
        chk("fill_full", {31'h0, full}, 32'h1);
        enq(6'd9, 32'h9, 32'h480, 3'd2, 1'b0);
        chk("fill_overflow", {31'h0, overflow}, 32'h1);
        for (int t = 1; t <= 4; t++) cyc(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b1, 6'(t), 1'b0, 1'b1, 32'h0);
        repeat (10) idle(1'b1);
        chk("fill_drained", {31'h0, empty}, 32'h1);

        // Flush keeps only the committed entry
        enq(6'd7, 32'h7, 32'h500, 3'd2, 1'b0);
        enq(6'd8, 32'h8, 32'h504, 3'd2, 1'b0);
        enq(6'd9, 32'h9, 32'h508, 3'd2, 1'b0);
        cyc(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b1, 6'd7, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
        chk("flush_keeps_committed", {31'h0, empty}, 32'h0);
        repeat (3) idle(1'b1);
        chk("flush_drained", {31'h0, empty}, 32'h1);
        enq(6'd10, 32'hA, 32'h50C, 3'd2, 1'b1);
        idle(1'b0);
        idle(1'b1);

        // Same-cycle enqueue+commit, and enqueue+flush
        enq(6'd3, 32'h3333_3333, 32'h600, 3'd2, 1'b1);
        idle(1'b0);
        chk("enq_commit_req", {31'h0, mem_req}, 32'h1);
        idle(1'b1);
        cyc(1'b1, 6'd4, 32'h4, 32'h604, 3'd2, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
        chk("enq_flush_dropped", {31'h0, empty}, 32'h1);

        // Load aliasing and misaligned SW
        enq(6'd11, 32'h55, 32'h300, 3'd2, 1'b0);
        cyc(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h302);
        chk("alias_hit", {31'h0, load_conflict}, 32'h1);
        cyc(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h304);
        chk("alias_miss", {31'h0, load_conflict}, 32'h0);
        cyc(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h0);
        enq(6'd12, 32'hCAFE_F00D, 32'h301, 3'd2, 1'b1);
        idle(1'b0);
        chk("mis_pulse", {31'h0, misalign}, 32'h1);
        chk("mis_be", {28'h0, mem_byteEn}, 32'hF);
        chk("mis_addr", mem_addr, 32'h300);
        idle(1'b1);

        // Reset in the middle of a handshake
        enq(6'd13, 32'h1313_1313, 32'h700, 3'd2, 1'b1);
        idle(1'b0);
        chk("midrst_req_before", {31'h0, mem_req}, 32'h1);
        #2;
        reset = 1'b0;
        zero_inputs();
        #1;
        chk("midrst_req_dropped", {31'h0, mem_req}, 32'h0);
        do_reset();

        // Randomised traffic with in-order commits
        nt = 6'd40;
        for (int c = 0; c < 1500; c++) begin
            se = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 9);
            st = (pick < 3) ? 3'd0 : (pick < 6) ? 3'd1 : (pick < 9) ? 3'd2 : 3'($urandom_range(3, 7));
            a = 32'h300 + 32'($urandom_range(0, 31));
            idx = -1;
            for (int i = mq.size() - 1; i >= 0; i--) if (!mq[i].cmt) idx = i;
            cv = 1'b0;
            cr = nt + 6'd32;
            if (idx >= 0 && $urandom_range(0, 9) < 4) begin cv = 1'b1; cr = mq[idx].tag; end
            else if (idx < 0 && se && $urandom_range(0, 9) < 3) begin cv = 1'b1; cr = nt; end
            else if ($urandom_range(0, 9) == 0) cv = 1'b1;
            fl = ($urandom_range(0, 19) == 0);
            ak = ($urandom_range(0, 9) < 5);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                la = mq[$urandom_range(0, mq.size() - 1)].addr ^ 32'($urandom_range(0, 3));
            else
                la = 32'h300 + 32'($urandom_range(0, 39));
            cyc(se, nt, $urandom(), a, st, cv, cr, fl, ak, la);
        end

        // Final drain: discard uncommitted work and ack everything outstanding
        cyc(1'b0, 6'd0, 32'h0, 32'h0, 3'd0, 1'b0, 6'd0, 1'b1, 1'b1, 32'h0);
        for (int c = 0; c < 40 && (mq.size() != 0 || busy); c++) idle(1'b1);
        repeat (2) idle(1'b1);
        chk("drain_model_empty", {31'h0, mq.size() == 0 && !busy}, 32'h1);
        chk("drain_requests_seen", 32'(eq.size()), 32'h0);
        chk("drain_dut_empty", {31'h0, empty}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
